mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 90 +++++++++
 tb/tb_mem_wb_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage data memory with MEM/WB pipeline register and forwarding
module mem_wb_stage #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IaluResult,
    input  logic [7:0] Ir2,
    input  logic [2:0] Idest,
    input  logic       IDMMemWrite,
    input  logic       IregWrite,
    input  logic       IregWriteDataSel,
    input  logic       stall,
    input  logic       flush,
    output logic [7:0] OwbData,
    output logic [2:0] Odest,
    output logic       OregWrite,
    output logic [7:0] OfwdData,
    output logic [2:0] OfwdDest,
    output logic       OfwdValid
);

    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [7:0]        mem_q [MEM_DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        mem_result;
    logic              store_en;

    logic [7:0]        wb_data_q, wb_data_d;
    logic [2:0]        dest_q, dest_d;
    logic              reg_write_q, reg_write_d;

    // Upper address bits are dropped so accesses wrap modulo MEM_DEPTH.
    assign addr       = IaluResult[ADDR_W-1:0];
    assign mem_rdata  = mem_q[addr];
    assign mem_result = IregWriteDataSel ? mem_rdata : IaluResult;
    assign store_en   = IDMMemWrite & ~stall & ~flush;

    // Data memory: async clear, store on edge; reads see pre-edge contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (store_en) begin
            mem_q[addr] <= Ir2;
        end
    end

    // MEM/WB next state: flush inserts a bubble and beats stall, stall holds.
    always_comb begin
        wb_data_d   = wb_data_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            wb_data_d   = 8'h00;
            dest_d      = 3'd0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            wb_data_d   = mem_result;
            dest_d      = Idest;
            reg_write_d = IregWrite;
        end
    end

    // MEM/WB register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_q   <= 8'h00;
            dest_q      <= 3'd0;
            reg_write_q <= 1'b0;
        end else begin
            wb_data_q   <= wb_data_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign OwbData   = wb_data_q;
    assign Odest     = dest_q;
    assign OregWrite = reg_write_q;

    // Forwarding path straight from the MEM stage, invalidated by flush.
    assign OfwdData  = mem_result;
    assign OfwdDest  = Idest;
    assign OfwdValid = IregWrite & ~flush;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard testbench for mem_wb_stage
module tb_mem_wb_stage;

    localparam int DEPTH = 128;

    logic       clk;
    logic       rst;
    logic [7:0] IaluResult;
    logic [7:0] Ir2;
    logic [2:0] Idest;
    logic       IDMMemWrite;
    logic       IregWrite;
    logic       IregWriteDataSel;
    logic       stall;
    logic       flush;
    logic [7:0] OwbData;
    logic [2:0] Odest;
    logic       OregWrite;
    logic [7:0] OfwdData;
    logic [2:0] OfwdDest;
    logic       OfwdValid;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0] exp_q [$];
    logic [11:0] last_exp;
    logic [11:0] exp;
    logic [7:0]  ref_mem [DEPTH];

    mem_wb_stage #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .IaluResult(IaluResult), .Ir2(Ir2), .Idest(Idest),
        .IDMMemWrite(IDMMemWrite), .IregWrite(IregWrite),
        .IregWriteDataSel(IregWriteDataSel),
        .stall(stall), .flush(flush),
        .OwbData(OwbData), .Odest(Odest), .OregWrite(OregWrite),
        .OfwdData(OfwdData), .OfwdDest(OfwdDest), .OfwdValid(OfwdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] wb_obs();
        return {OwbData, Odest, OregWrite};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] r2, input logic [2:0] d,
                         input logic mw, input logic rw, input logic sel,
                         input logic st, input logic fl);
        IaluResult = a; Ir2 = r2; Idest = d; IDMMemWrite = mw;
        IregWrite = rw; IregWriteDataSel = sel; stall = st; flush = fl;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [2:0] dst, input logic rw);
        last_exp = {d, dst, rw};
        exp_q.push_back(last_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic [11:0] e);
        if (exp_q.size() == 0) begin
            e = 12'hxxx;
            $display("FAIL scoreboard_empty: got size 0 required >0");
            n_fail++;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        #2;
        n_cmp++;
        if (wb_obs() !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 000", wb_obs());
        end
        drive(8'h10, 8'hFF, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (wb_obs() !== 12'h000) begin
            n_fail++; $display("FAIL reset_hold_edge: got %h required 000", wb_obs());
        end
        @(negedge clk);
        rst = 1'b1;
        drive(8'h10, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(8'h00, 3'd0, 1'b0);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL reset_store_ignored: got %h required %h", wb_obs(), exp);
        end
    endtask

    task automatic test_store_load();
        drive(8'h10, 8'hA5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h10, 3'd0, 1'b0);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL store_cycle: got %h required %h", wb_obs(), exp);
        end
        drive(8'h10, 8'h00, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'hA5, 3'd3, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL store_then_load: got %h required %h", wb_obs(), exp);
        end
        ref_mem[8'h10] = 8'hA5;
    endtask

    task automatic test_alu_pass();
        drive(8'h7E, 8'h00, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if ({OfwdData, OfwdDest, OfwdValid} !== {8'h7E, 3'd5, 1'b1}) begin
            n_fail++; $display("FAIL alu_forward: got %h %h %b required 7e 5 1", OfwdData, OfwdDest, OfwdValid);
        end
        push_exp(8'h7E, 3'd5, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL alu_writeback: got %h required %h", wb_obs(), exp);
        end
    endtask

    task automatic test_stall();
        drive(8'h30, 8'h22, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h30, 3'd0, 1'b0);
        tick();
        pop_exp(exp);
        drive(8'h30, 8'h00, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h22, 3'd2, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL stall_preload: got %h required %h", wb_obs(), exp);
        end
        for (int c = 0; c < 2; c++) begin
            drive(8'h20, 8'hEE, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            push_exp(8'h22, 3'd2, 1'b1);
            tick();
            pop_exp(exp); n_cmp++;
            if (wb_obs() !== exp) begin
                n_fail++; $display("FAIL stall_hold_%0d: got %h required %h", c, wb_obs(), exp);
            end
        end
        drive(8'h20, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h00, 3'd1, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL stall_no_store: got %h required %h", wb_obs(), exp);
        end
        ref_mem[8'h30] = 8'h22;
    endtask

    task automatic test_flush();
        drive(8'h40, 8'h33, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (OfwdValid !== 1'b0) begin
            n_fail++; $display("FAIL flush_fwd_valid: got %b required 0", OfwdValid);
        end
        push_exp(8'h00, 3'd0, 1'b0);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL flush_bubble: got %h required %h", wb_obs(), exp);
        end
        drive(8'h40, 8'h00, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h00, 3'd4, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL flush_no_store: got %h required %h", wb_obs(), exp);
        end
    endtask

    task automatic test_same_cycle();
        drive(8'h08, 8'h11, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h08, 3'd0, 1'b0);
        tick();
        pop_exp(exp);
        drive(8'h08, 8'h99, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h11, 3'd4, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL same_cycle_old_data: got %h required %h", wb_obs(), exp);
        end
        drive(8'h08, 8'h00, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h99, 3'd6, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL same_cycle_new_data: got %h required %h", wb_obs(), exp);
        end
    endtask

    task automatic test_wrap_dest0();
        drive(8'h85, 8'h6C, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h85, 3'd0, 1'b0);
        tick();
        pop_exp(exp);
        drive(8'h05, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h6C, 3'd0, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL wrap_dest0: got %h required %h", wb_obs(), exp);
        end
    endtask

    task automatic test_async_reset();
        drive(8'h01, 8'h5A, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h01, 3'd0, 1'b0);
        tick();
        pop_exp(exp);
        drive(8'h01, 8'h00, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h5A, 3'd7, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL async_preload: got %h required %h", wb_obs(), exp);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (wb_obs() !== 12'h000) begin
            n_fail++; $display("FAIL async_clear: got %h required 000", wb_obs());
        end
        drive(8'h02, 8'h77, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        drive(8'h01, 8'h00, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h00, 3'd3, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL async_mem_cleared: got %h required %h", wb_obs(), exp);
        end
        drive(8'h02, 8'h00, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(8'h00, 3'd2, 1'b1);
        tick();
        pop_exp(exp); n_cmp++;
        if (wb_obs() !== exp) begin
            n_fail++; $display("FAIL async_store_ignored: got %h required %h", wb_obs(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, r2, res;
        logic [2:0]  d;
        logic        mw, rw, sel, st, fl;
        for (int c = 0; c < 60; c++) begin
            a   = 8'($urandom_range(0, 255));
            r2  = 8'($urandom_range(0, 255));
            d   = 3'($urandom_range(0, 7));
            mw  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            if (c < 16) a = {4'h0, 4'(c)};
            drive(a, r2, d, mw, rw, sel, st, fl);
            res = sel ? ref_mem[a[6:0]] : a;
            #1;
            n_cmp++;
            if ({OfwdData, OfwdDest, OfwdValid} !== {res, d, rw & ~fl}) begin
                n_fail++;
                $display("FAIL b2b_fwd_%0d: got %h %h %b required %h %h %b",
                         c, OfwdData, OfwdDest, OfwdValid, res, d, rw & ~fl);
            end
            if (fl) push_exp(8'h00, 3'd0, 1'b0);
            else if (st) push_exp(last_exp[11:4], last_exp[3:1], last_exp[0]);
            else push_exp(res, d, rw);
            if (mw && !st && !fl) ref_mem[a[6:0]] = r2;
            tick();
            pop_exp(exp); n_cmp++;
            if (wb_obs() !== exp) begin
                n_fail++; $display("FAIL b2b_wb_%0d: got %h required %h", c, wb_obs(), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_alu_pass();
        test_stall();
        test_flush();
        test_same_cycle();
        test_wrap_dest0();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion required completion");
        $fatal(1);
    end

endmodule
